// File: rtl/drac_pkg.sv
// Shared types for the rename-table checkpoint machinery: pointer widths,
// per-checkpoint status and scheduler FSM encodings.
package drac_pkg;

  localparam int unsigned NUM_CHECKPOINTS = 4;
  localparam int unsigned CKPT_PTR_W      = $clog2(NUM_CHECKPOINTS);
  localparam int unsigned CKPT_CNT_W      = CKPT_PTR_W + 1;
  localparam int unsigned STALL_CNT_W     = 3;
  localparam int unsigned STAT_W          = 32;

  typedef logic [CKPT_PTR_W-1:0] checkpoint_ptr;
  typedef logic [CKPT_CNT_W-1:0] checkpoint_cnt;

  typedef enum logic [1:0] {
    CKPT_FREE = 2'd0,
    CKPT_PEND = 2'd1,
    CKPT_OK   = 2'd2
  } ckpt_state_t;

  typedef enum logic [1:0] {
    SCHED_RUN = 2'd0,
    SCHED_REC = 2'd1,
    SCHED_EXC = 2'd2
  } ckpt_sched_fsm_t;

  typedef struct packed {
    logic [STAT_W-1:0] stall_cycles;
    logic [STAT_W-1:0] recovers;
    logic [STAT_W-1:0] grants;
  } ckpt_sched_stats_t;

  // Distance from b forward to a, modulo the (power-of-two) checkpoint count.
  function automatic checkpoint_ptr ptr_dist(input checkpoint_ptr a, input checkpoint_ptr b);
    return a - b;
  endfunction

endpackage

// File: rtl/checkpoint_scheduler_window.sv
// Combinational membership test of a checkpoint id against the live window
// [tail, tail+count) taken modulo NUM_CHECKPOINTS.
module ckpt_window_check
  import drac_pkg::*;
(
  input  checkpoint_ptr id_i,
  input  checkpoint_ptr tail_i,
  input  checkpoint_cnt count_i,
  output logic          in_window_o
);

  assign in_window_o = (CKPT_CNT_W'(ptr_dist(id_i, tail_i)) < count_i);

endmodule

// File: rtl/checkpoint_scheduler.sv
// Checkpoint grant / retire / recover sequencer for the rename table.
// Optional statistics counters and stats_o port when CKPT_SCHED_STATS_EN is defined.
module checkpoint_scheduler
  import drac_pkg::*;
#(
  parameter int unsigned RECOVER_STALL = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ckpt_req_i,
  output logic          ckpt_grant_o,
  output checkpoint_ptr ckpt_id_o,
  input  logic          resolve_valid_i,
  input  checkpoint_ptr resolve_id_i,
  input  logic          resolve_mispredict_i,
  input  logic          exception_i,
  output logic          do_checkpoint_o,
  output logic          do_recover_o,
  output checkpoint_ptr recover_checkpoint_o,
  output logic          delete_checkpoint_o,
  output logic          recover_commit_o,
  output logic          stall_o
`ifdef CKPT_SCHED_STATS_EN
  ,
  output ckpt_sched_stats_t stats_o
`endif
);

  localparam checkpoint_cnt CNT_FULL = CKPT_CNT_W'(NUM_CHECKPOINTS - 1);

  ckpt_state_t                status_q [NUM_CHECKPOINTS];
  ckpt_state_t                status_d [NUM_CHECKPOINTS];
  checkpoint_ptr              head_q, head_d;
  checkpoint_ptr              tail_q, tail_d;
  checkpoint_cnt              count_q, count_d;
  ckpt_sched_fsm_t            state_q, state_d;
  logic [STALL_CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic                       do_recover_q, do_recover_d;
  checkpoint_ptr              recover_ckpt_q, recover_ckpt_d;
  logic                       delete_q, delete_d;
  logic                       commit_q, commit_d;

  logic                       resolve_in_window;
  logic                       resolve_live;
  logic                       recover_now;
  logic                       resolve_ok;
  logic                       tail_ok;
  logic                       delete_now;
  logic                       grant;
  checkpoint_ptr              resolve_off;

  ckpt_window_check u_window (
    .id_i        (resolve_id_i),
    .tail_i      (tail_q),
    .count_i     (count_q),
    .in_window_o (resolve_in_window)
  );

  // A resolve for a squashed (out-of-window or freed) branch is dropped here.
  assign resolve_live = resolve_valid_i & resolve_in_window &
                        (status_q[resolve_id_i] != CKPT_FREE);
  assign recover_now  = resolve_live & resolve_mispredict_i & ~exception_i;
  assign resolve_ok   = resolve_live & ~resolve_mispredict_i & ~exception_i;
  assign resolve_off  = ptr_dist(resolve_id_i, tail_q);

  // The tail retires on the same cycle its branch is confirmed.
  assign tail_ok    = (status_q[tail_q] == CKPT_OK) | (resolve_ok & (resolve_id_i == tail_q));
  assign delete_now = (count_q != '0) & tail_ok & ~recover_now & ~exception_i;
  assign grant      = ckpt_req_i & (state_q == SCHED_RUN) & (count_q < CNT_FULL) &
                      ~recover_now & ~exception_i;

  assign ckpt_grant_o         = grant;
  assign do_checkpoint_o      = grant;
  assign ckpt_id_o            = head_q;
  assign do_recover_o         = do_recover_q;
  assign recover_checkpoint_o = recover_ckpt_q;
  assign delete_checkpoint_o  = delete_q;
  assign recover_commit_o     = commit_q;
  assign stall_o              = (state_q != SCHED_RUN) | (count_q == CNT_FULL) |
                                do_recover_q | commit_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_CHECKPOINTS); i++) status_q[i] <= CKPT_FREE;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      state_q        <= SCHED_RUN;
      stall_cnt_q    <= '0;
      do_recover_q   <= 1'b0;
      recover_ckpt_q <= '0;
      delete_q       <= 1'b0;
      commit_q       <= 1'b0;
    end else begin
      status_q       <= status_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      state_q        <= state_d;
      stall_cnt_q    <= stall_cnt_d;
      do_recover_q   <= do_recover_d;
      recover_ckpt_q <= recover_ckpt_d;
      delete_q       <= delete_d;
      commit_q       <= commit_d;
    end
  end

  // Next state: exception beats mispredict, which beats grant/delete.
  always_comb begin
    status_d       = status_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    do_recover_d   = recover_now;
    recover_ckpt_d = recover_ckpt_q;
    delete_d       = delete_now;
    commit_d       = exception_i;

    if (exception_i) begin
      for (int i = 0; i < int'(NUM_CHECKPOINTS); i++) status_d[i] = CKPT_FREE;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      state_d     = SCHED_EXC;
      stall_cnt_d = '0;
    end else if (recover_now) begin
      for (int i = 0; i < int'(NUM_CHECKPOINTS); i++) begin
        if (ptr_dist(CKPT_PTR_W'(i), tail_q) >= resolve_off) status_d[i] = CKPT_FREE;
      end
      head_d         = resolve_id_i;
      count_d        = CKPT_CNT_W'(resolve_off);
      recover_ckpt_d = resolve_id_i;
      state_d        = SCHED_REC;
      stall_cnt_d    = STALL_CNT_W'(RECOVER_STALL);
    end else begin
      case (state_q)
        SCHED_REC: begin
          if (stall_cnt_q == '0) state_d = SCHED_RUN;
          else                   stall_cnt_d = stall_cnt_q - STALL_CNT_W'(1);
        end
        SCHED_EXC: state_d = SCHED_RUN;
        default:   state_d = state_q;
      endcase
      if (resolve_ok) status_d[resolve_id_i] = CKPT_OK;
      if (grant) begin
        status_d[head_q] = CKPT_PEND;
        head_d           = head_q + CKPT_PTR_W'(1);
      end
      if (delete_now) begin
        status_d[tail_q] = CKPT_FREE;
        tail_d           = tail_q + CKPT_PTR_W'(1);
      end
      count_d = count_q + CKPT_CNT_W'(grant) - CKPT_CNT_W'(delete_now);
    end
  end

`ifdef CKPT_SCHED_STATS_EN
  ckpt_sched_stats_t stats_q;

  // Saturating event counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stats_q <= '0;
    end else begin
      if (grant && (stats_q.grants != '1))
        stats_q.grants <= stats_q.grants + STAT_W'(1);
      if (recover_now && (stats_q.recovers != '1))
        stats_q.recovers <= stats_q.recovers + STAT_W'(1);
      if (stall_o && (stats_q.stall_cycles != '1))
        stats_q.stall_cycles <= stats_q.stall_cycles + STAT_W'(1);
    end
  end

  assign stats_o = stats_q;
`endif

endmodule

// File: tb/tb_checkpoint_scheduler.sv
// Self-checking bench for checkpoint_scheduler: directed table, corner
// sequences and random traffic against a queue-based reference model.
module tb_checkpoint_scheduler;
  import drac_pkg::*;

  localparam int N  = 4;
  localparam int RS = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req, rv, mp, exc;
  checkpoint_ptr rid;
  logic          ckpt_grant_o, do_checkpoint_o, do_recover_o;
  logic          delete_checkpoint_o, recover_commit_o, stall_o;
  checkpoint_ptr ckpt_id_o, recover_checkpoint_o;

  checkpoint_scheduler #(.RECOVER_STALL(RS)) dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .ckpt_req_i           (req),
    .ckpt_grant_o         (ckpt_grant_o),
    .ckpt_id_o            (ckpt_id_o),
    .resolve_valid_i      (rv),
    .resolve_id_i         (rid),
    .resolve_mispredict_i (mp),
    .exception_i          (exc),
    .do_checkpoint_o      (do_checkpoint_o),
    .do_recover_o         (do_recover_o),
    .recover_checkpoint_o (recover_checkpoint_o),
    .delete_checkpoint_o  (delete_checkpoint_o),
    .recover_commit_o     (recover_commit_o),
    .stall_o              (stall_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: live checkpoints held oldest-first in a queue.
  int q_id[$];
  bit q_ok[$];
  int m_head;
  int m_rec_left;
  bit m_exc, m_rec_p, m_del_p, m_com_p;
  int m_rec_id;

  task automatic model_reset();
    q_id.delete();
    q_ok.delete();
    m_head = 0; m_rec_left = 0; m_exc = 0;
    m_rec_p = 0; m_del_p = 0; m_com_p = 0; m_rec_id = 0;
  endtask

  task automatic cycle(input bit i_req, input bit i_rv, input int i_rid,
                       input bit i_mp, input bit i_exc);
    int p;
    bit run, rec_now, ok_now, g, d, st;
    @(negedge clk);
    req = i_req; rv = i_rv; rid = checkpoint_ptr'(i_rid); mp = i_mp; exc = i_exc;
    #1;
    p = -1;
    foreach (q_id[k]) if (q_id[k] == i_rid) p = k;
    run     = (m_rec_left == 0) && !m_exc;
    rec_now = i_rv && i_mp && (p >= 0) && !i_exc;
    ok_now  = i_rv && !i_mp && (p >= 0) && !i_exc;
    g       = i_req && run && (q_id.size() < N-1) && !rec_now && !i_exc;
    st      = !run || (q_id.size() == N-1) || m_rec_p || m_com_p;
    d       = (q_id.size() > 0) && (q_ok[0] || (ok_now && p == 0)) && !rec_now && !i_exc;

    check("grant", int'(ckpt_grant_o), int'(g));
    check("do_checkpoint", int'(do_checkpoint_o), int'(g));
    check("ckpt_id", int'(ckpt_id_o), m_head);
    check("stall", int'(stall_o), int'(st));
    check("do_recover", int'(do_recover_o), int'(m_rec_p));
    if (m_rec_p) check("recover_id", int'(recover_checkpoint_o), m_rec_id);
    check("delete", int'(delete_checkpoint_o), int'(m_del_p));
    check("recover_commit", int'(recover_commit_o), int'(m_com_p));

    m_rec_p = rec_now;
    if (rec_now) m_rec_id = i_rid;
    m_del_p = d;
    m_com_p = i_exc;
    if (i_exc) begin
      q_id.delete(); q_ok.delete();
      m_head = 0; m_rec_left = 0; m_exc = 1;
    end else begin
      m_exc = 0;
      if (rec_now) begin
        while (q_id.size() > p) begin
          void'(q_id.pop_back());
          void'(q_ok.pop_back());
        end
        m_head = i_rid;
        m_rec_left = RS + 1;
      end else begin
        if (ok_now) q_ok[p] = 1;
        if (d) begin
          void'(q_id.pop_front());
          void'(q_ok.pop_front());
        end
        if (g) begin
          q_id.push_back(m_head);
          q_ok.push_back(0);
          m_head = (m_head + 1) % N;
        end
        if (m_rec_left > 0) m_rec_left--;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1; req = 0; rv = 0; rid = '0; mp = 0; exc = 0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 0;
    model_reset();
  endtask

  typedef struct packed {
    logic       req, rv;
    logic [1:0] rid;
    logic       mp, exc;
    logic       g;
    logic [1:0] id;
    logic       st, rec;
    logic [1:0] rec_id;
    logic       del, com;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int a_req, a_rv, a_rid, a_mp, a_exc,
                              input int e_g, e_id, e_st, e_rec, e_rid, e_del, e_com);
    vec_t v;
    v.req = 1'(a_req); v.rv = 1'(a_rv); v.rid = 2'(a_rid); v.mp = 1'(a_mp); v.exc = 1'(a_exc);
    v.g = 1'(e_g); v.id = 2'(e_id); v.st = 1'(e_st); v.rec = 1'(e_rec);
    v.rec_id = 2'(e_rid); v.del = 1'(e_del); v.com = 1'(e_com);
    return v;
  endfunction

  initial begin
    rst_i = 1; req = 0; rv = 0; rid = '0; mp = 0; exc = 0;
    // Fill, mispredict, stale resolve, in-order retire, exception priority.
    tbl.push_back(mk(1,0,0,0,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1,2,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 0,3,1,0,0,0,0));
    tbl.push_back(mk(0,1,1,1,0, 0,3,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,1,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,0,0,0,0));
    tbl.push_back(mk(0,1,2,1,0, 0,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0, 0,2,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,2,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,2,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,2,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0,0, 1,2,0,0,0,0,0));
    tbl.push_back(mk(1,1,2,1,1, 0,3,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,1,0,0,0,0,0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].req, tbl[i].rv, int'(tbl[i].rid), tbl[i].mp, tbl[i].exc);
      check($sformatf("tbl%0d_grant", i), int'(ckpt_grant_o), int'(tbl[i].g));
      check($sformatf("tbl%0d_id", i), int'(ckpt_id_o), int'(tbl[i].id));
      check($sformatf("tbl%0d_stall", i), int'(stall_o), int'(tbl[i].st));
      check($sformatf("tbl%0d_recover", i), int'(do_recover_o), int'(tbl[i].rec));
      if (tbl[i].rec)
        check($sformatf("tbl%0d_recover_id", i), int'(recover_checkpoint_o), int'(tbl[i].rec_id));
      check($sformatf("tbl%0d_delete", i), int'(delete_checkpoint_o), int'(tbl[i].del));
      check($sformatf("tbl%0d_commit", i), int'(recover_commit_o), int'(tbl[i].com));
    end

    // Wrap-around: 10 grant/retire pairs, then mispredict id 3 with tail 2.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, i % N, 0, 0);
    end
    cycle(1, 0, 0, 0, 0);
    check("wrap_grant_id", int'(ckpt_id_o), 2);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 3, 1, 0);
    cycle(0, 0, 0, 0, 0);
    check("wrap_recover", int'(do_recover_o), 1);
    check("wrap_recover_id", int'(recover_checkpoint_o), 3);
    check("wrap_head", int'(ckpt_id_o), 3);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("wrap_after_grant", int'(ckpt_grant_o), 1);
    cycle(0, 1, 2, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Reset asserted while the recover pulse is out.
    cycle(0, 1, 3, 1, 0);
    @(negedge clk);
    rst_i = 1; req = 0; rv = 0; mp = 0; exc = 0;
    #1;
    check("midrst_pulse_before", int'(do_recover_o), 1);
    @(negedge clk);
    rst_i = 0;
    model_reset();
    #1;
    check("midrst_recover", int'(do_recover_o), 0);
    check("midrst_stall", int'(stall_o), 0);
    check("midrst_id", int'(ckpt_id_o), 0);
    check("midrst_commit", int'(recover_commit_o), 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      bit b_rv;
      b_rv = ($urandom_range(0, 1) == 1);
      cycle($urandom_range(0, 9) < 6, b_rv, int'($urandom_range(0, N-1)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
